dynamixel_status_parser: RTL
============================

DYNAMIXEL_STATUS_PARSER -- requirements
Module: dynamixel_status_parser

Interface
REQ-001 SHALL have parameter MAX_PARAMS, default 4, max status parameter bytes captured (1..4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, cycles from arm to forced timeout (1 ms at 50 MHz).
REQ-003 SHALL use a single clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  in  1  system clock (CLOCK_50 domain), all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port arm  in  1  one-cycle pulse; start listening for one status packet.
REQ-007 SHALL have port expect_id  in  8  servo ID to accept; sampled on arm; 0xFE accepts any ID.
REQ-008 SHALL have port rx_valid  in  1  one-cycle strobe, rx_byte holds a received UART byte.
REQ-009 SHALL have port rx_byte  in  8  received byte, valid only with rx_valid.
REQ-010 SHALL have port busy  out  1  high from the cycle after arm until done.
REQ-011 SHALL have port done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port id  out  8  ID field of the accepted packet.
REQ-013 SHALL have port error  out  8  servo error byte.
REQ-014 SHALL have port param_count  out  3  number of parameter bytes (LEN-2).
REQ-015 SHALL have port params  out  32  parameter bytes, first byte in [7:0], unused bytes 0.
REQ-016 SHALL have port chk_ok  out  1  checksum matched.
REQ-017 SHALL have port timeout  out  1  no complete packet within TIMEOUT_CYCLES.
REQ-018 SHALL have port frame_err  out  1  illegal LEN field.

Function
REQ-019 SHALL implement states IDLE, HDR1, HDR2, ID, LEN, ERR, PARAM, CHK; only rx_valid cycles advance HDR1..CHK.
REQ-020 SHALL in IDLE ignore rx_valid; on arm, latch expect_id, clear id/error/param_count/params/chk_ok/timeout/frame_err, zero timer, go HDR1.
REQ-021 SHALL in HDR1 go HDR2 on 0xFF, else stay; in HDR2 go ID on 0xFF, else HDR1.
REQ-022 SHALL in ID stay on 0xFF (extra preamble); on mismatch (expect_id != 0xFE and byte != expect_id) drop silently to HDR1; else store id, go LEN.
REQ-023 SHALL in LEN, if LEN<2 or LEN-2>MAX_PARAMS, set frame_err, pulse done, go IDLE; else store, go ERR.
REQ-024 SHALL in ERR store error, go PARAM if LEN>2, else CHK.
REQ-025 SHALL in PARAM store byte k at params[8k+7:8k], go CHK after LEN-2 bytes.
REQ-026 SHALL compute checksum as bitwise NOT of 8-bit modulo sum of ID, LEN, ERR and params; carries discarded.
REQ-027 SHALL in CHK set chk_ok=(byte==checksum), set param_count, pulse done next cycle, go IDLE.
REQ-028 SHALL assert timeout and pulse done, go IDLE, when the timer reaches TIMEOUT_CYCLES while busy; a packet completing on that same cycle wins (timeout=0).
REQ-029 SHALL on arm while busy abort current packet without done and restart per REQ-020.
REQ-030 SHALL hold all result outputs stable from done until the next arm.
REQ-031 SHALL never assert done twice per arm.

Reset
REQ-032 SHALL on reset_n low immediately force IDLE, busy=0, done=0, all result outputs 0, timer 0, including mid-packet.
REQ-033 SHALL require a new arm after reset release before accepting bytes.

Verification
REQ-034 SHALL verify: arm expect_id=0x01, bytes FF FF 01 02 00 FC -> done, id=01, error=00, param_count=0, chk_ok=1.
REQ-035 SHALL verify: bytes FF FF 01 04 00 20 02 D8 -> params=0x00000220, param_count=2, chk_ok=1; same with last byte D7 -> chk_ok=0.
REQ-036 SHALL verify: noise FF 00 FF FF FF 01 02 00 FC and preceding packet with ID 0x03 -> only ID 01 packet reported, one done.
REQ-037 SHALL verify: arm then no bytes -> done at cycle TIMEOUT_CYCLES with timeout=1, chk_ok=0.
REQ-038 SHALL verify: FF FF 01 09 -> frame_err=1, done immediately; FF FF 01 01 -> frame_err=1.
REQ-039 SHALL verify: reset_n pulled low after FF FF 01 -> all outputs 0; subsequent bytes without arm ignored.

Source files
------------

// File: rtl/dynamixel_status_parser.sv
// Dynamixel protocol 1.0 status packet receiver: arm, hunt for FF FF,
// filter by servo ID, capture ERR/params, verify checksum or time out.
module dynamixel_status_parser #(
    parameter int unsigned MAX_PARAMS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        arm,
    input  logic [7:0]  expect_id,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        busy,
    output logic        done,
    output logic [7:0]  id,
    output logic [7:0]  error,
    output logic [2:0]  param_count,
    output logic [31:0] params,
    output logic        chk_ok,
    output logic        timeout,
    output logic        frame_err
);

    localparam int unsigned TW         = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  MAX_LEN    = 8'(MAX_PARAMS + 2);
    localparam logic [7:0]  ANY_ID     = 8'hFE;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR1, S_HDR2, S_ID, S_LEN, S_ERR, S_PARAM, S_CHK
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      exp_id;
    logic [7:0]      len_r;
    logic [7:0]      sum;
    logic [2:0]      pidx;
    logic [TW-1:0]   timer;

    logic            id_match_c;
    logic            last_param_c;
    logic            ld_id_c;
    logic            ld_len_c;
    logic            ld_err_c;
    logic            ld_param_c;
    logic            ld_chk_c;
    logic            frame_c;
    logic            to_c;

    assign id_match_c   = (exp_id == ANY_ID) || (rx_byte == exp_id);
    assign last_param_c = (({5'd0, pidx} + 8'd1) == (len_r - 8'd2));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next state and capture strobes; arm restarts, a completing byte beats the timer
    always_comb begin
        state_nxt  = state;
        ld_id_c    = 1'b0;
        ld_len_c   = 1'b0;
        ld_err_c   = 1'b0;
        ld_param_c = 1'b0;
        ld_chk_c   = 1'b0;
        frame_c    = 1'b0;
        to_c       = 1'b0;
        if (arm) begin
            state_nxt = S_HDR1;
        end else begin
            if (rx_valid) begin
                unique case (state)
                    S_HDR1:  state_nxt = (rx_byte == 8'hFF) ? S_HDR2 : S_HDR1;
                    S_HDR2:  state_nxt = (rx_byte == 8'hFF) ? S_ID : S_HDR1;
                    S_ID: begin
                        if (rx_byte == 8'hFF) begin
                            state_nxt = S_ID;
                        end else if (!id_match_c) begin
                            state_nxt = S_HDR1;
                        end else begin
                            ld_id_c   = 1'b1;
                            state_nxt = S_LEN;
                        end
                    end
                    S_LEN: begin
                        if ((rx_byte < 8'd2) || (rx_byte > MAX_LEN)) begin
                            frame_c   = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            ld_len_c  = 1'b1;
                            state_nxt = S_ERR;
                        end
                    end
                    S_ERR: begin
                        ld_err_c  = 1'b1;
                        state_nxt = (len_r > 8'd2) ? S_PARAM : S_CHK;
                    end
                    S_PARAM: begin
                        ld_param_c = 1'b1;
                        if (last_param_c) state_nxt = S_CHK;
                    end
                    S_CHK: begin
                        ld_chk_c  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                    default: ;
                endcase
            end
            if ((state != S_IDLE) && (state_nxt != S_IDLE) && (timer == TIMER_LAST)) begin
                to_c       = 1'b1;
                ld_id_c    = 1'b0;
                ld_len_c   = 1'b0;
                ld_err_c   = 1'b0;
                ld_param_c = 1'b0;
                state_nxt  = S_IDLE;
            end
        end
    end

    // Datapath: result capture, running checksum, timer, busy/done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_id      <= 8'd0;
            len_r       <= 8'd0;
            sum         <= 8'd0;
            pidx        <= 3'd0;
            timer       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id          <= 8'd0;
            error       <= 8'd0;
            param_count <= 3'd0;
            params      <= 32'd0;
            chk_ok      <= 1'b0;
            timeout     <= 1'b0;
            frame_err   <= 1'b0;
        end else if (arm) begin
            exp_id      <= expect_id;
            len_r       <= 8'd0;
            sum         <= 8'd0;
            pidx        <= 3'd0;
            timer       <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            id          <= 8'd0;
            error       <= 8'd0;
            param_count <= 3'd0;
            params      <= 32'd0;
            chk_ok      <= 1'b0;
            timeout     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            done <= ld_chk_c | frame_c | to_c;
            busy <= (state_nxt != S_IDLE);
            if (state != S_IDLE) timer <= timer + TW'(1);
            if (ld_id_c) begin
                id  <= rx_byte;
                sum <= rx_byte;
            end
            if (ld_len_c) begin
                len_r <= rx_byte;
                sum   <= sum + rx_byte;
            end
            if (ld_err_c) begin
                error <= rx_byte;
                sum   <= sum + rx_byte;
                pidx  <= 3'd0;
            end
            if (ld_param_c) begin
                params <= params | ({24'd0, rx_byte} << {pidx[1:0], 3'b000});
                sum    <= sum + rx_byte;
                pidx   <= pidx + 3'd1;
            end
            if (ld_chk_c) begin
                chk_ok      <= (rx_byte == ~sum);
                param_count <= 3'(len_r - 8'd2);
            end
            if (frame_c) frame_err <= 1'b1;
            if (to_c)    timeout   <= 1'b1;
        end
    end

endmodule
